s_axil_regbank: RTL and testbench
=================================

Name: s_axil_regbank

Overview:
- Parametrised AXI4-Lite slave register bank; successor to the fixed-map control register block.
- Provides N_CTRL read/write control registers, each with a per-register reset value and an optional self-clearing (pulse) mode.
- Provides N_STAT read-only status registers, driven from fabric, with a read strobe for clear-on-read sources.
- Decodes the address range and answers SLVERR for invalid accesses; sits between the PS AXI-Lite interconnect and the correlator/snapshot datapath.

Parameters:
- DATA_WIDTH, 32, bus and register width; multiple of 8.
- ADDR_WIDTH, 4, word-address bits; byte address is ADDR_WIDTH+2 bits, with bits [1:0] ignored.
- N_CTRL, 8, number of control registers at word addresses 0..N_CTRL-1.
- N_STAT, 8, number of status registers at word addresses N_CTRL..N_CTRL+N_STAT-1; N_CTRL+N_STAT <= 2**ADDR_WIDTH.
- PULSE_MASK, 0, N_CTRL-bit vector; bit k=1 makes control register k self-clearing.
- CTRL_RESET, 0, N_CTRL*DATA_WIDTH flattened reset values; register k occupies [k*DATA_WIDTH +: DATA_WIDTH].

Ports:
- axi_clock  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- s_axil_aw{addr,prot,valid,ready}, s_axil_w{data,strb,valid,ready}, s_axil_b{resp,valid,ready}, s_axil_ar{addr,prot,valid,ready}, s_axil_r{data,resp,valid,ready}: standard AXI4-Lite widths; addr is ADDR_WIDTH+2 bits; prot is ignored.
- ctrl_regs  out  N_CTRL*DATA_WIDTH  current control register values, flattened.
- ctrl_wr_stb  out  N_CTRL  one-cycle pulse per register on the cycle after a committed write.
- stat_regs  in  N_STAT*DATA_WIDTH  status values, flattened.
- stat_rd_stb  out  N_STAT  one-cycle pulse on the cycle the status value is sampled.

Behaviour:
- Reset (rst=1 at an edge):
  - ctrl regs load CTRL_RESET; bvalid, rvalid, all strobes and the hold flags go to 0.
  - awready, wready, arready are 0 during reset and rise to 1 on the first edge with rst=0.
  - rdata=0, bresp=rresp=0.
  - Reset mid-transaction drops that transaction: no response and no register update.
- Write address/data:
  - AW and W are accepted independently, each into a one-entry hold register.
  - awready = !aw_held; wready = !w_held.
- Write commit:
  - Occurs on the edge where both an AW and a W are available (held, or handshaking this cycle) and !(bvalid && !bready).
  - On commit: decode the word address; bvalid=1 on the next cycle; both hold flags clear so readies are 1 next cycle.
  - Back-to-back commits every cycle are allowed while bready=1.
- Decode:
  - addr < N_CTRL: update bytes where wstrb=1; bresp=OKAY; ctrl_wr_stb[k] pulses on the following cycle.
  - Status range or unmapped address: no state change; bresp=SLVERR (2'b10).
- B channel: bvalid holds until bready; a pending commit stalls while bvalid && !bready.
- Pulse registers (PULSE_MASK[k]=1):
  - The written value is visible for exactly one cycle, then the register returns to CTRL_RESET[k].
  - A commit in the clear cycle wins over the clear.
- Read:
  - arready = !rvalid || rready.
  - On the AR handshake, data is registered: rvalid=1 and rdata valid on the next cycle (latency 1).
  - rdata/rresp hold while rvalid && !rready.
  - Full throughput: one read per cycle with rready=1.
- Read decode:
  - ctrl range returns the register value; status range returns stat_regs sampled at the handshake edge, with stat_rd_stb[j] pulsing that same cycle.
  - Unmapped address returns rdata=0, rresp=SLVERR.
- Read/write same register in the same cycle: the read returns the pre-write value.
- Read and write channels are fully independent; there is no ordering between them.

Decomposition:
- Package regbank_pkg holds:
  - the RESP_OKAY=2'b00 and RESP_SLVERR=2'b10 constants;
  - a function for word-address range checks;
  - a function for byte-strobe merge of DATA_WIDTH-wide words.
- One sub-module, axil_wr_hold: a one-entry hold buffer with valid/ready, instantiated for AW (addr) and W (data+strb).
- Read path and register array stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles with CTRL_RESET[1]=0x0000_00FF -> ctrl reg1=0xFF, bvalid=rvalid=0, readies=1 one cycle after rst falls.
- Split write: AW addr=0x04 at cycle 0, W data=0xDEADBEEF strb=4'b0101 at cycle 3 -> reg1=0x00AD00EF, bresp=OKAY at cycle 4, ctrl_wr_stb[1] pulse at cycle 5.
- Backpressure: 3 back-to-back writes with bready=0 for 5 cycles -> exactly one commit; awready/wready drop after the second beat; remaining writes complete in order once bready=1; no data lost.
- Pulse: PULSE_MASK[0]=1, write 0x1 to addr 0 -> ctrl reg0=1 for exactly 1 cycle, then 0; read back returns 0.
- Status read: stat_regs[2]=0x1234 at the AR handshake on addr (N_CTRL+2)*4 -> rdata=0x1234, OKAY one cycle later; stat_rd_stb[2] pulses once.
- Errors: write to a status address and read addr 0x3C with N_CTRL+N_STAT=16... use N_CTRL+N_STAT=12 -> bresp=SLVERR with no register change; read of addr 0x3C returns rresp=SLVERR, rdata=0.

Source files
------------

// File: rtl/s_axil_regbank_pkg.sv
// Shared response codes and word-level helpers for the AXI4-Lite register bank.
package regbank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Widest register word the merge helper handles; callers size-cast in and out.
    localparam int MAX_DATA_WIDTH = 256;
    localparam int MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

    // True when a word address lies in [base, base+count).
    function automatic logic word_in_range(input int word, input int base, input int count);
        return (word >= base) && (word < (base + count));
    endfunction

    // Replace the bytes of old_word whose strobe bit is set with those of new_word.
    function automatic logic [MAX_DATA_WIDTH-1:0] strobe_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_STRB_WIDTH-1:0] strb
    );
        logic [MAX_DATA_WIDTH-1:0] result;
        result = old_word;
        for (int b = 0; b < MAX_STRB_WIDTH; b++) begin
            if (strb[b]) begin
                result[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/s_axil_regbank_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the register bank (slave).
interface s_axil_regbank_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) ();

    logic [ADDR_WIDTH+1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;

    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ADDR_WIDTH+1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;

    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );

endinterface

// File: rtl/s_axil_regbank_wr_hold.sv
// One-entry hold buffer for a write channel: a beat can be consumed the cycle it
// arrives, or parked here until the other write channel catches up.
module axil_wr_hold #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             take
);

    logic             held;
    logic [WIDTH-1:0] buffer;

    assign in_ready  = enable && !held;
    assign out_valid = held || (in_valid && in_ready);
    assign out_data  = held ? buffer : in_data;

    // Park an accepted beat unless it is consumed in the same cycle; consuming empties the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            held   <= 1'b0;
            buffer <= '0;
        end else if (take) begin
            held <= 1'b0;
        end else if (in_valid && in_ready) begin
            held   <= 1'b1;
            buffer <= in_data;
        end
    end

endmodule

// File: rtl/s_axil_regbank.sv
// AXI4-Lite slave register bank: N_CTRL read/write control registers (optionally
// self-clearing) followed by N_STAT read-only status words sampled from fabric.
module s_axil_regbank
    import regbank_pkg::*;
#(
    parameter int                           DATA_WIDTH = 32,
    parameter int                           ADDR_WIDTH = 4,
    parameter int                           N_CTRL     = 8,
    parameter int                           N_STAT     = 8,
    parameter logic [N_CTRL-1:0]            PULSE_MASK = '0,
    parameter logic [N_CTRL*DATA_WIDTH-1:0] CTRL_RESET = '0
) (
    input  logic                         axi_clock,
    input  logic                         rst,
    s_axil_regbank_if.slave              s_axil,
    output logic [N_CTRL*DATA_WIDTH-1:0] ctrl_regs,
    output logic [N_CTRL-1:0]            ctrl_wr_stb,
    input  logic [N_STAT*DATA_WIDTH-1:0] stat_regs,
    output logic [N_STAT-1:0]            stat_rd_stb
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int W_WIDTH    = DATA_WIDTH + STRB_WIDTH;

    logic                  ready_en;

    logic                  aw_avail;
    logic                  w_avail;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] wr_word;
    logic [W_WIDTH-1:0]    w_beat;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_WIDTH-1:0] wr_strb;
    logic                  wr_is_ctrl;

    logic [DATA_WIDTH-1:0] ctrl_q    [N_CTRL];
    logic [DATA_WIDTH-1:0] wr_merged [N_CTRL];
    logic [N_CTRL-1:0]     wr_hit;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;

    logic                  arready_int;
    logic                  ar_hs;
    logic [ADDR_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_data_next;
    logic [1:0]            rd_resp_next;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;

    logic                  unused_bits;

    assign unused_bits = ^{s_axil.awprot, s_axil.arprot, s_axil.awaddr[1:0], s_axil.araddr[1:0]};

    // Readies stay low through reset and come up on the first clean edge afterwards.
    always_ff @(posedge axi_clock) begin
        if (rst) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    axil_wr_hold #(
        .WIDTH(ADDR_WIDTH)
    ) aw_hold (
        .clk      (axi_clock),
        .rst      (rst),
        .enable   (ready_en),
        .in_data  (s_axil.awaddr[ADDR_WIDTH+1:2]),
        .in_valid (s_axil.awvalid),
        .in_ready (s_axil.awready),
        .out_valid(aw_avail),
        .out_data (wr_word),
        .take     (commit)
    );

    axil_wr_hold #(
        .WIDTH(W_WIDTH)
    ) w_hold (
        .clk      (axi_clock),
        .rst      (rst),
        .enable   (ready_en),
        .in_data  ({s_axil.wstrb, s_axil.wdata}),
        .in_valid (s_axil.wvalid),
        .in_ready (s_axil.wready),
        .out_valid(w_avail),
        .out_data (w_beat),
        .take     (commit)
    );

    assign wr_data    = w_beat[DATA_WIDTH-1:0];
    assign wr_strb    = w_beat[W_WIDTH-1:DATA_WIDTH];
    assign commit     = aw_avail && w_avail && !(bvalid_q && !s_axil.bready);
    assign wr_is_ctrl = word_in_range(int'(wr_word), 0, N_CTRL);

    // Byte-strobe merge of the pending write data onto every control register's current value.
    always_comb begin
        for (int k = 0; k < N_CTRL; k++) begin
            wr_merged[k] = DATA_WIDTH'(strobe_merge(MAX_DATA_WIDTH'(ctrl_q[k]),
                                                    MAX_DATA_WIDTH'(wr_data),
                                                    MAX_STRB_WIDTH'(wr_strb)));
        end
    end

    // Control registers, write response and delayed write strobes; a commit beats a pulse clear.
    always_ff @(posedge axi_clock) begin
        if (rst) begin
            for (int k = 0; k < N_CTRL; k++) begin
                ctrl_q[k] <= CTRL_RESET[k*DATA_WIDTH +: DATA_WIDTH];
            end
            wr_hit      <= '0;
            ctrl_wr_stb <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
        end else begin
            ctrl_wr_stb <= wr_hit;
            wr_hit      <= '0;
            for (int k = 0; k < N_CTRL; k++) begin
                if (PULSE_MASK[k]) begin
                    ctrl_q[k] <= CTRL_RESET[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_is_ctrl ? RESP_OKAY : RESP_SLVERR;
                for (int k = 0; k < N_CTRL; k++) begin
                    if (wr_is_ctrl && (int'(wr_word) == k)) begin
                        ctrl_q[k] <= wr_merged[k];
                        wr_hit[k] <= 1'b1;
                    end
                end
            end else if (s_axil.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Flatten the register array onto the fabric-facing output.
    always_comb begin
        ctrl_regs = '0;
        for (int k = 0; k < N_CTRL; k++) begin
            ctrl_regs[k*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[k];
        end
    end

    assign s_axil.bvalid = bvalid_q;
    assign s_axil.bresp  = bresp_q;

    assign arready_int    = ready_en && (!rvalid_q || s_axil.rready);
    assign s_axil.arready = arready_int;
    assign ar_hs          = s_axil.arvalid && arready_int;
    assign rd_word        = s_axil.araddr[ADDR_WIDTH+1:2];

    // Read decode; a status word is sampled and its read strobe fired on the handshake cycle.
    always_comb begin
        rd_data_next = '0;
        rd_resp_next = RESP_SLVERR;
        stat_rd_stb  = '0;
        if (word_in_range(int'(rd_word), 0, N_CTRL)) begin
            rd_resp_next = RESP_OKAY;
            for (int k = 0; k < N_CTRL; k++) begin
                if (int'(rd_word) == k) begin
                    rd_data_next = ctrl_q[k];
                end
            end
        end else if (word_in_range(int'(rd_word), N_CTRL, N_STAT)) begin
            rd_resp_next = RESP_OKAY;
            for (int j = 0; j < N_STAT; j++) begin
                if (int'(rd_word) == (N_CTRL + j)) begin
                    rd_data_next   = stat_regs[j*DATA_WIDTH +: DATA_WIDTH];
                    stat_rd_stb[j] = ar_hs;
                end
            end
        end
    end

    // Read data channel: register on handshake, hold while the master stalls.
    always_ff @(posedge axi_clock) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data_next;
            rresp_q  <= rd_resp_next;
        end else if (s_axil.rready) begin
            rvalid_q <= 1'b0;
        end
    end

    assign s_axil.rvalid = rvalid_q;
    assign s_axil.rdata  = rdata_q;
    assign s_axil.rresp  = rresp_q;

endmodule

// File: tb/tb_s_axil_regbank.sv
// Scoreboard bench for s_axil_regbank: stimulus pushes expected B/R responses,
// a negedge monitor pops and compares them whenever a response handshakes.
module tb_s_axil_regbank;
    import regbank_pkg::*;

    localparam int DW     = 32;
    localparam int AW     = 4;
    localparam int N_CTRL = 8;
    localparam int N_STAT = 4;
    localparam logic [N_CTRL*DW-1:0] TB_CTRL_RESET = (N_CTRL*DW)'(32'h0000_00FF) << DW;
    localparam logic [N_CTRL-1:0]    TB_PULSE_MASK = 8'h01;
    localparam int CH_AW = 0;
    localparam int CH_W  = 1;
    localparam int CH_AR = 2;
    localparam int HANDSHAKE_LIMIT = 100;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rExp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N_CTRL*DW-1:0] ctrl_regs;
    logic [N_CTRL-1:0]    ctrl_wr_stb;
    logic [N_STAT*DW-1:0] stat_regs;
    logic [N_STAT-1:0]    stat_rd_stb;

    int totalCount = 0;
    int badCount   = 0;
    logic [1:0] expB [$];
    rExp_t      expR [$];
    logic [1:0] bExpected;
    rExp_t      rExpected;
    int statStbCount [N_STAT];
    int otherStb;

    s_axil_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    s_axil_regbank #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .N_CTRL    (N_CTRL),
        .N_STAT    (N_STAT),
        .PULSE_MASK(TB_PULSE_MASK),
        .CTRL_RESET(TB_CTRL_RESET)
    ) dut (
        .axi_clock  (clk),
        .rst        (rst),
        .s_axil     (bus),
        .ctrl_regs  (ctrl_regs),
        .ctrl_wr_stb(ctrl_wr_stb),
        .stat_regs  (stat_regs),
        .stat_rd_stb(stat_rd_stb)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ctrlReg(input int k);
        return ctrl_regs[k*DW +: DW];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalCount++;
        if (actual !== expected) begin
            badCount++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Drive one beat on a channel and wait (bounded) for its handshake; expected responses are queued here.
    task automatic applyStimulus(input int channel, input logic [5:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, input logic [31:0] expData, input logic [1:0] expResp);
        rExp_t r;
        logic  gotReady;
        int    waitCycles;
        if (channel == CH_AW) begin
            expB.push_back(expResp);
            bus.awaddr  = addr;
            bus.awvalid = 1'b1;
        end else if (channel == CH_W) begin
            bus.wdata  = data;
            bus.wstrb  = strb;
            bus.wvalid = 1'b1;
        end else begin
            r.data = expData;
            r.resp = expResp;
            expR.push_back(r);
            bus.araddr  = addr;
            bus.arvalid = 1'b1;
        end
        gotReady   = 1'b0;
        waitCycles = 0;
        while (!gotReady) begin
            @(negedge clk);
            if ((channel == CH_AW && bus.awready) || (channel == CH_W && bus.wready) ||
                (channel == CH_AR && bus.arready)) begin
                gotReady = 1'b1;
            end else begin
                waitCycles++;
                if (waitCycles >= HANDSHAKE_LIMIT) begin
                    totalCount++;
                    badCount++;
                    $display("[TB] FAIL handshake_timeout channel=%0d actual=no ready required=ready within %0d cycles",
                             channel, HANDSHAKE_LIMIT);
                    gotReady = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        if (channel == CH_AW) bus.awvalid = 1'b0;
        else if (channel == CH_W) bus.wvalid = 1'b0;
        else bus.arvalid = 1'b0;
    endtask

    // Response monitor: compare each B and R handshake against the head of its scoreboard queue.
    always @(negedge clk) begin
        if (!rst && bus.bvalid && bus.bready) begin
            if (expB.size() == 0) begin
                totalCount++;
                badCount++;
                $display("[TB] FAIL b_unexpected actual=bresp %b required=no response", bus.bresp);
            end else begin
                bExpected = expB.pop_front();
                checkOutput("bresp", 32'(bus.bresp), 32'(bExpected));
            end
        end
        if (!rst && bus.rvalid && bus.rready) begin
            if (expR.size() == 0) begin
                totalCount++;
                badCount++;
                $display("[TB] FAIL r_unexpected actual=rdata %h required=no response", bus.rdata);
            end else begin
                rExpected = expR.pop_front();
                checkOutput("rdata", bus.rdata, rExpected.data);
                checkOutput("rresp", 32'(bus.rresp), 32'(rExpected.resp));
            end
        end
        for (int j = 0; j < N_STAT; j++) begin
            if (stat_rd_stb[j]) statStbCount[j]++;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        repeat (20000) @(posedge clk);
        $display("[TB] FAIL watchdog actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        for (int j = 0; j < N_STAT; j++) begin
            statStbCount[j] = 0;
            stat_regs[j*DW +: DW] = 32'hA000_0000 + 32'(j);
        end
        stat_regs[2*DW +: DW] = 32'h0000_1234;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_reg1", ctrlReg(1), 32'h0000_00FF);
        checkOutput("reset_reg0", ctrlReg(0), 32'h0);
        checkOutput("reset_bvalid", 32'(bus.bvalid), 32'h0);
        checkOutput("reset_rvalid", 32'(bus.rvalid), 32'h0);
        checkOutput("reset_readies_low", 32'({bus.awready, bus.wready, bus.arready}), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("readies_up", 32'({bus.awready, bus.wready, bus.arready}), 32'h7);

        // Split write: AW first, W three cycles later.
        fork
            applyStimulus(CH_AW, 6'h04, 32'h0, 4'h0, 32'h0, RESP_OKAY);
            begin
                repeat (3) @(posedge clk);
                #1;
                applyStimulus(CH_W, 6'h00, 32'hDEAD_BEEF, 4'b0101, 32'h0, RESP_OKAY);
            end
        join
        checkOutput("split_reg1", ctrlReg(1), 32'h00AD_00EF);
        checkOutput("split_bvalid", 32'(bus.bvalid), 32'h1);
        checkOutput("split_stb_early", 32'(ctrl_wr_stb), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("split_stb_pulse", 32'(ctrl_wr_stb), 32'h2);
        @(posedge clk);
        #1;
        checkOutput("split_stb_end", 32'(ctrl_wr_stb), 32'h0);

        // Pulse register 0: value lives for exactly one cycle.
        fork
            applyStimulus(CH_AW, 6'h00, 32'h0, 4'h0, 32'h0, RESP_OKAY);
            applyStimulus(CH_W, 6'h00, 32'h0000_0001, 4'hF, 32'h0, RESP_OKAY);
        join
        checkOutput("pulse_high", ctrlReg(0), 32'h1);
        @(posedge clk);
        #1;
        checkOutput("pulse_cleared", ctrlReg(0), 32'h0);

        // Backpressure: three writes while bready is held low for five cycles.
        bus.bready = 1'b0;
        fork
            begin
                applyStimulus(CH_AW, 6'h08, 32'h0, 4'h0, 32'h0, RESP_OKAY);
                applyStimulus(CH_AW, 6'h0C, 32'h0, 4'h0, 32'h0, RESP_OKAY);
                applyStimulus(CH_AW, 6'h10, 32'h0, 4'h0, 32'h0, RESP_OKAY);
            end
            begin
                applyStimulus(CH_W, 6'h00, 32'h1111_1111, 4'hF, 32'h0, RESP_OKAY);
                applyStimulus(CH_W, 6'h00, 32'h2222_2222, 4'hF, 32'h0, RESP_OKAY);
                applyStimulus(CH_W, 6'h00, 32'h3333_3333, 4'hF, 32'h0, RESP_OKAY);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                checkOutput("bp_awready_low", 32'(bus.awready), 32'h0);
                checkOutput("bp_wready_low", 32'(bus.wready), 32'h0);
                checkOutput("bp_reg2_one_commit", ctrlReg(2), 32'h1111_1111);
                checkOutput("bp_reg3_stalled", ctrlReg(3), 32'h0);
                bus.bready = 1'b1;
            end
        join
        repeat (2) @(posedge clk);
        #1;
        checkOutput("bp_reg3", ctrlReg(3), 32'h2222_2222);
        checkOutput("bp_reg4", ctrlReg(4), 32'h3333_3333);

        // Write to a status address: SLVERR, no register change, no strobe.
        fork
            applyStimulus(CH_AW, 6'h20, 32'h0, 4'h0, 32'h0, RESP_SLVERR);
            applyStimulus(CH_W, 6'h00, 32'hFFFF_FFFF, 4'hF, 32'h0, RESP_OKAY);
        join
        @(posedge clk);
        #1;
        checkOutput("err_no_stb", 32'(ctrl_wr_stb), 32'h0);
        checkOutput("err_reg1_kept", ctrlReg(1), 32'h00AD_00EF);
        checkOutput("err_reg0_kept", ctrlReg(0), 32'h0);

        // Back-to-back reads across ctrl, status and unmapped space.
        applyStimulus(CH_AR, 6'h04, 32'h0, 4'h0, 32'h00AD_00EF, RESP_OKAY);
        applyStimulus(CH_AR, 6'h00, 32'h0, 4'h0, 32'h0, RESP_OKAY);
        applyStimulus(CH_AR, 6'h0C, 32'h0, 4'h0, 32'h2222_2222, RESP_OKAY);
        applyStimulus(CH_AR, 6'h28, 32'h0, 4'h0, 32'h0000_1234, RESP_OKAY);
        applyStimulus(CH_AR, 6'h3C, 32'h0, 4'h0, 32'h0, RESP_SLVERR);
        applyStimulus(CH_AR, 6'h30, 32'h0, 4'h0, 32'h0, RESP_SLVERR);

        repeat (10) @(posedge clk);
        #1;
        checkOutput("b_queue_drained", 32'(expB.size()), 32'h0);
        checkOutput("r_queue_drained", 32'(expR.size()), 32'h0);
        checkOutput("stat2_stb_count", 32'(statStbCount[2]), 32'h1);
        otherStb = statStbCount[0] + statStbCount[1] + statStbCount[3];
        checkOutput("stat_other_stb", 32'(otherStb), 32'h0);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
